// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + single-issue sequencer around a combinational ALU, with a
// valid/ready result register. Optional error counter: ALU_SEQ_ERR_CNT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [BITS-1:0] i_cmd_a,
  input  logic [BITS-1:0] i_cmd_b,
  input  logic [1:0]      i_cmd_op,
  output logic [BITS-1:0] o_alu_a,
  output logic [BITS-1:0] o_alu_b,
  output logic [1:0]      o_alu_op,
  input  logic [BITS-1:0] i_alu_out,
  input  logic            i_alu_carry,
  input  logic            i_alu_err,
  input  logic            i_alu_even,
  input  logic            i_alu_single,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [BITS-1:0] o_res_data,
  output logic [3:0]      o_res_flags,
  output logic [1:0]      o_res_op,
`ifdef ALU_SEQ_ERR_CNT_EN
  output logic [7:0]      o_err_cnt,
`endif
  output logic            o_busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = 2 * BITS + 2;
  localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LAT_W-1:0] wait_cnt;
  logic [LAT_W-1:0] wait_cnt_nxt;
  logic             push;
  logic             pop;
  logic             capture;
  logic             res_accept;

  // o_cmd_ready is a registered copy of !full, so this is the plain handshake
  assign push = i_cmd_valid & o_cmd_ready;

  // Next-state and strobe decode
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pop          = 1'b0;
    capture      = 1'b0;
    res_accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop          = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wait_cnt == LAT_W'(ALU_LAT - 1)) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          wait_cnt_nxt = wait_cnt + LAT_W'(1);
        end
      end
      S_HOLD: begin
        if (i_res_ready) begin
          res_accept = 1'b1;
          if (count != '0) begin
            pop          = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_cmd_a, i_cmd_b, i_cmd_op};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_cmd_ready <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count       <= count_nxt;
      o_cmd_ready <= (count_nxt != CNT_W'(DEPTH));
      o_busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
    end
  end

  // ALU operand and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_flags <= '0;
      o_res_op    <= '0;
    end else begin
      if (pop) begin
        {o_alu_a, o_alu_b, o_alu_op} <= mem[rd_ptr];
      end
      if (capture) begin
        o_res_valid <= 1'b1;
        o_res_data  <= i_alu_out;
        o_res_flags <= {i_alu_err, i_alu_carry, i_alu_even, i_alu_single};
        o_res_op    <= o_alu_op;
      end else if (res_accept) begin
        o_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_ERR_CNT_EN
  // Saturating count of captures that reported an ALU error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
    end else if (capture && i_alu_err && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural stub ALU whose
// error flag can be forced.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_carry, alu_err, alu_even, alu_single;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_flags;
  logic [1:0] res_op;
  logic       busy;
  logic       force_err = 1'b0;
  logic [8:0] diff;
`ifdef ALU_SEQ_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.BITS(8), .DEPTH(4), .ALU_LAT(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_a      (cmd_a),
    .i_cmd_b      (cmd_b),
    .i_cmd_op     (cmd_op),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_out    (alu_out),
    .i_alu_carry  (alu_carry),
    .i_alu_err    (alu_err),
    .i_alu_even   (alu_even),
    .i_alu_single (alu_single),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_data   (res_data),
    .o_res_flags  (res_flags),
    .o_res_op     (res_op),
`ifdef ALU_SEQ_ERR_CNT_EN
    .o_err_cnt    (err_cnt),
`endif
    .o_busy       (busy)
  );

  // Stub ALU: sub(borrow), cmp(a>b, eq), shl1(msb out), xor; even = LSB clear
  always_comb begin
    diff      = {1'b0, alu_a} - {1'b0, alu_b};
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_op)
      2'b00: begin alu_out = diff[7:0]; alu_carry = diff[8]; end
      2'b01: begin alu_out = (alu_a > alu_b) ? 8'd1 : 8'd0; alu_carry = (alu_a == alu_b); end
      2'b10: begin alu_out = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      default: begin alu_out = alu_a ^ alu_b; alu_carry = 1'b0; end
    endcase
    alu_err    = force_err;
    alu_even   = ~alu_out[0];
    alu_single = $onehot(alu_out);
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int n = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 8'h00) begin failures++; $display("FAIL reset_res_data got=%h exp=00", res_data); end
    checks++; if ({alu_a, alu_b, alu_op} !== 18'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_op}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
`ifdef ALU_SEQ_ERR_CNT_EN
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = 2'b00;
    @(negedge clk);  // edge N accepted
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk);  // after N+1
    checks++; if ({alu_a, alu_b} !== 16'h0503) begin failures++; $display("FAIL single_alu_operands got=%h exp=0503", {alu_a, alu_b}); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", res_valid); end
    @(negedge clk);  // after N+2
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    checks++; if (res_data !== 8'h02) begin failures++; $display("FAIL single_data got=%h exp=02", res_data); end
    checks++; if (res_op !== 2'b00) begin failures++; $display("FAIL single_op got=%b exp=00", res_op); end
    checks++; if (res_flags !== 4'b0011) begin failures++; $display("FAIL single_flags got=%b exp=0011", res_flags); end
    @(negedge clk);  // consumed at N+3
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int cyc_seen [3];
    logic [7:0] dat_seen [3];
    res_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (res_valid && got < 3) begin cyc_seen[got] = k; dat_seen[got] = res_data; got++; end
      cmd_valid = (k < 3); cmd_a = 8'(k + 1); cmd_b = 8'h00; cmd_op = 2'b11;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if (got !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got); end
    if (got == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (dat_seen[i] !== 8'(i + 1)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, dat_seen[i], 8'(i + 1)); end
      end
      checks++; if (cyc_seen[0] !== 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=3", cyc_seen[0]); end
      for (int i = 1; i < 3; i++) begin
        checks++; if (cyc_seen[i] - cyc_seen[i-1] !== 2) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=2", i, cyc_seen[i] - cyc_seen[i-1]); end
      end
    end
  endtask

  task automatic test_fill();
    int idx = 0;
    int got = 0;
    logic rdy_prev = 1'b0;
    res_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (cmd_valid && rdy_prev) idx++;
      cmd_valid = (idx < 6); cmd_a = 8'(8'h10 + idx); cmd_b = 8'h00; cmd_op = 2'b11;
      rdy_prev = cmd_ready;
      @(negedge clk);
    end
    if (cmd_valid && rdy_prev) idx++;
    cmd_valid = 1'b0;
    checks++; if (idx !== 5) begin failures++; $display("FAIL fill_accepted got=%0d exp=5", idx); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h10) begin failures++; $display("FAIL fill_held got=%b/%h exp=1/10", res_valid, res_data); end
    res_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (res_valid) begin
        checks++; if (res_data !== 8'(8'h10 + got) || res_op !== 2'b11) begin failures++; $display("FAIL fill_order[%0d] got=%h/%b exp=%h/11", got, res_data, res_op, 8'(8'h10 + got)); end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got !== 5) begin failures++; $display("FAIL fill_result_count got=%0d exp=5", got); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b/%b exp=0/1", busy, cmd_ready); end
  endtask

  task automatic test_stall();
    int n = 0;
    int got = 0;
    res_ready = 1'b0;
    push_cmd(8'h40, 8'h00, 2'b11);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    push_cmd(8'h41, 8'h00, 2'b11);
    for (int k = 0; k < 10; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 8'h40 || alu_a !== 8'h40) begin
        failures++; $display("FAIL stall_hold[%0d] valid=%b data=%h alu_a=%h exp=1/40/40", k, res_valid, res_data, alu_a);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (res_valid) begin
        checks++; if (res_data !== 8'(8'h40 + got)) begin failures++; $display("FAIL stall_drain[%0d] got=%h exp=%h", got, res_data, 8'(8'h40 + got)); end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got !== 2) begin failures++; $display("FAIL stall_result_count got=%0d exp=2", got); end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_data [4];
    logic [3:0] exp_flags [4];
    exp_data[0] = 8'hA9; exp_flags[0] = 4'b0000;
    exp_data[1] = 8'h01; exp_flags[1] = 4'b0001;
    exp_data[2] = 8'h54; exp_flags[2] = 4'b0110;
    exp_data[3] = 8'hAB; exp_flags[3] = 4'b0000;
    res_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      int n = 0;
      push_cmd(8'hAA, 8'h01, 2'(op));
      while (!res_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (res_valid !== 1'b1 || res_data !== exp_data[op] || res_flags !== exp_flags[op] || res_op !== 2'(op)) begin
        failures++; $display("FAIL sweep_op%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", op, res_valid, res_data, res_flags, res_op, exp_data[op], exp_flags[op], 2'(op));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n = 0;
    res_ready = 1'b0;
    push_cmd(8'h77, 8'h00, 2'b11);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    push_cmd(8'h78, 8'h00, 2'b11);
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00 || res_flags !== 4'h0 || res_op !== 2'b00) begin
      failures++; $display("FAIL midrst_res got=%b/%h/%b/%b exp=0/00/0000/00", res_valid, res_data, res_flags, res_op);
    end
    checks++; if (alu_a !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_ctrl alu_a=%h busy=%b ready=%b exp=00/0/1", alu_a, busy, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    push_cmd(8'h05, 8'h03, 2'b00);
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (res_valid !== 1'b1 || res_data !== 8'h02) begin failures++; $display("FAIL midrst_next got=%b/%h exp=1/02", res_valid, res_data); end
    repeat (4) @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_flushed valid=%b busy=%b exp=0/0", res_valid, busy); end
  endtask

`ifdef ALU_SEQ_ERR_CNT_EN
  task automatic test_err_cnt();
    int acc = 0;
    int guard = 0;
    logic rdy_prev = 1'b0;
    checks++; if (err_cnt !== 8'h00) begin failures++; $display("FAIL errcnt_start got=%h exp=00", err_cnt); end
    force_err = 1'b1;
    res_ready = 1'b1;
    while (acc < 300 && guard < 3000) begin
      if (cmd_valid && rdy_prev) acc++;
      cmd_valid = (acc < 300); cmd_a = 8'(acc); cmd_b = 8'h01; cmd_op = 2'b00;
      rdy_prev = cmd_ready;
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin @(negedge clk); guard++; end
    checks++; if (acc !== 300) begin failures++; $display("FAIL errcnt_pushes got=%0d exp=300", acc); end
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL errcnt_saturate got=%h exp=ff", err_cnt); end
    checks++; if (res_flags[3] !== 1'b1) begin failures++; $display("FAIL errcnt_flag got=%b exp=1", res_flags[3]); end
    force_err = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_stall();
    test_op_sweep();
    test_reset_mid_hold();
`ifdef ALU_SEQ_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
